// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader.
// State encoding and frame length width.
package program_loader_pkg;

  localparam int LOADER_LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } ldr_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into 32-bit words.
// clear/byte_en/byte_in in; byte_idx, word_valid pulse, word out.
module word_assembler #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] shreg;
  logic [31:0] shnext;

  always_comb begin
    shnext = BIG_ENDIAN ? {shreg[23:0], byte_in}
                        : {byte_in, shreg[31:8]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg      <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        shreg    <= '0;
        byte_idx <= '0;
      end else if (byte_en) begin
        shreg    <= shnext;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          word_valid <= 1'b1;
          word       <= shnext;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed image into imem, then releases the core.
// Byte stream in, imem write port out, core reset and status out.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int CW = LOADER_LEN_W + 1;
  localparam logic [CW-1:0] MAX_N = CW'(2 ** ADDR_W);

  ldr_state_e state, state_nx;

  logic [LOADER_LEN_W-1:0] len_q;
  logic [LOADER_LEN_W-1:0] len_nx;
  logic [7:0]              csum_q;
  logic [ADDR_W:0]         words_q;
  logic                    xfer;
  logic                    load_fire;
  logic                    last_byte;
  logic [1:0]              byte_idx;
  logic                    word_valid;
  logic [31:0]             word;

  assign xfer   = in_valid && in_ready;
  assign len_nx = {len_q[15:8], in_data};

  assign load_fire = load_start &&
    (state == IDLE || state == DONE ||
     state == ERROR);

  // A word's write lags its 4th byte by one
  // cycle, but the next 4th byte is at least
  // 3 cycles later, so words_q is settled here.
  assign last_byte = (byte_idx == 2'd3) &&
    ((CW'(words_q) + CW'(1)) == {1'b0, len_q});

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_rst_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) state_nx = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nx = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if ({1'b0, len_nx} > MAX_N)
            state_nx = ERROR;
          else if (len_nx == '0)
            state_nx = CHECK;
          else
            state_nx = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && last_byte) state_nx = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer)
          state_nx = (in_data == csum_q) ? DONE : ERROR;
      end
      DONE: begin
        done       = 1'b1;
        core_rst_n = 1'b1;
        if (load_start) state_nx = LEN_HI;
      end
      ERROR: begin
        error = 1'b1;
        if (load_start) state_nx = LEN_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      len_q   <= '0;
      csum_q  <= '0;
      words_q <= '0;
    end else begin
      state <= state_nx;
      if (load_fire) begin
        len_q   <= '0;
        csum_q  <= '0;
        words_q <= '0;
      end else begin
        if (state == LEN_HI && xfer)
          len_q[15:8] <= in_data;
        if (state == LEN_LO && xfer)
          len_q[7:0] <= in_data;
        if (state == LOAD && xfer)
          csum_q <= csum_q ^ in_data;
        if (word_valid)
          words_q <= words_q + 1'b1;
      end
    end
  end

  word_assembler #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_fire),
    .byte_en   (state == LOAD && xfer),
    .byte_in   (in_data),
    .byte_idx  (byte_idx),
    .word_valid(word_valid),
    .word      (word)
  );

  assign imem_we      = word_valid;
  assign imem_addr    = words_q[ADDR_W-1:0];
  assign imem_wdata   = word;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader, both byte orders.
// Reference model rebuilds expected imem image and status.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic        rdy_b, we_b, crn_b, busy_b, done_b, err_b;
  logic [9:0]  addr_b;
  logic [31:0] wd_b;
  logic [10:0] wl_b;
  logic        rdy_l, we_l, crn_l, busy_l, done_l, err_l;
  logic [9:0]  addr_l;
  logic [31:0] wd_l;
  logic [10:0] wl_l;

  int checks   = 0;
  int failures = 0;

  logic [31:0] frame_q[$];
  logic [9:0]  wa_b[$];
  logic [9:0]  wa_l[$];
  logic [31:0] wdq_b[$];
  logic [31:0] wdq_l[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .imem_we(we_b),
    .imem_addr(addr_b), .imem_wdata(wd_b),
    .core_rst_n(crn_b), .busy(busy_b),
    .done(done_b), .error(err_b),
    .words_loaded(wl_b)
  );

  program_loader #(.ADDR_W(10), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .imem_we(we_l),
    .imem_addr(addr_l), .imem_wdata(wd_l),
    .core_rst_n(crn_l), .busy(busy_l),
    .done(done_l), .error(err_l),
    .words_loaded(wl_l)
  );

  always @(negedge clk) begin
    if (we_b) begin
      wa_b.push_back(addr_b);
      wdq_b.push_back(wd_b);
    end
    if (we_l) begin
      wa_l.push_back(addr_l);
      wdq_l.push_back(wd_l);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic clear_writes();
    wa_b.delete();
    wa_l.delete();
    wdq_b.delete();
    wdq_l.delete();
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap_max);
    int gap;
    int t;
    gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!rdy_b && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("ready_seen", 32'(rdy_b && rdy_l), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic verify(input int n, input bit ok);
    int m;
    check("done_be", 32'(done_b), 32'(ok));
    check("done_le", 32'(done_l), 32'(ok));
    check("err_be", 32'(err_b), 32'(!ok));
    check("err_le", 32'(err_l), 32'(!ok));
    check("crn", {crn_b, crn_l}, {30'd0, ok, ok});
    check("idle_rb", {busy_b, busy_l, rdy_b, rdy_l}, 32'd0);
    check("wl_be", 32'(wl_b), 32'(n));
    check("wl_le", 32'(wl_l), 32'(n));
    check("we_cnt_be", 32'(wa_b.size()), 32'(n));
    check("we_cnt_le", 32'(wa_l.size()), 32'(n));
    m = (wa_b.size() < n) ? wa_b.size() : n;
    if (wa_l.size() < m) m = wa_l.size();
    for (int i = 0; i < m; i++) begin
      check("waddr_be", 32'(wa_b[i]), 32'(i));
      check("waddr_le", 32'(wa_l[i]), 32'(i));
      check("wdata_be", wdq_b[i], frame_q[i]);
      check("wdata_le", wdq_l[i], bswap(frame_q[i]));
    end
  endtask

  // Frame words are kept in stream order:
  // frame_q[i][31:24] is sent first.
  task automatic run_load(input int n, input bit corrupt,
                          input int gap, input int mid);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] len;
    cs  = 8'h00;
    len = 16'(n);
    clear_writes();
    pulse_start();
    check("start", {busy_b, done_b, err_b, crn_b,
                    busy_l, done_l, err_l, crn_l},
          32'b1000_1000);
    send_byte(len[15:8], gap);
    send_byte(len[7:0], gap);
    for (int i = 0; i < n; i++) begin
      w = frame_q[i];
      for (int j = 0; j < 4; j++) begin
        cs = cs ^ w[31-8*j -: 8];
        send_byte(w[31-8*j -: 8], gap);
        if (i == mid && j == 1) begin
          pulse_start();
          check("mid_busy", {busy_b, busy_l}, 32'd3);
        end
      end
    end
    check("pre_done", {done_b, done_l, crn_b}, 32'd0);
    send_byte(corrupt ? (cs ^ 8'h01) : cs, gap);
    verify(n, !corrupt);
  endtask

  task automatic rand_frame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++)
      frame_q.push_back($urandom);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      check("idle_ctl",
            {rdy_b, we_b, busy_b, done_b, err_b, crn_b,
             rdy_l, we_l, busy_l, done_l, err_l, crn_l},
            32'd0);
      check("idle_cnt", {wl_b, addr_b, wl_l, addr_l}, 32'd0);
      check("idle_wd", wd_b | wd_l, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    frame_q = '{32'h20010005, 32'h8C020010};
    run_load(2, 1'b0, 0, -1);
    run_load(2, 1'b1, 0, -1);

    frame_q.delete();
    run_load(0, 1'b0, 0, -1);

    clear_writes();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("oversize_err", {err_b, err_l, done_b, done_l},
          32'b1100);
    check("oversize_crn", {crn_b, crn_l, busy_b, rdy_b},
          32'd0);
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("oversize_rdy", {rdy_b, rdy_l}, 32'd0);
    check("oversize_we", 32'(wa_b.size() + wa_l.size()),
          32'd0);
    check("oversize_wl", 32'(wl_b), 32'd0);

    frame_q = '{32'h11223344, 32'hDEADBEEF, 32'h00000001};
    run_load(3, 1'b0, 3, 1);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(8, 1);
      rand_frame(n);
      run_load(n, 1'($urandom_range(1, 0)), 3,
               int'($urandom_range(n, 0)));
    end

    rand_frame(1024);
    run_load(1024, 1'b0, 0, -1);

    frame_q = '{32'hA5A5A5A5, 32'h12345678, 32'h0F0F0F0F};
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 1);
    for (int j = 0; j < 6; j++) send_byte(8'(j + 1), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_ctl",
          {rdy_b, busy_b, done_b, err_b, crn_b,
           rdy_l, busy_l, done_l, err_l, crn_l},
          32'd0);
    check("rst_wl", {wl_b, wl_l}, 32'd0);

    frame_q = '{32'hCAFEF00D};
    run_load(1, 1'b0, 1, -1);

    pulse_start();
    check("restart_crn", {crn_b, crn_l, done_b, done_l},
          32'd0);
    check("restart_busy", {busy_b, busy_l}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
